// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package loader_pkg;

  localparam int unsigned HeaderBytes = 4;

  typedef enum logic [2:0] {
    StHeader,
    StPayload,
    StReleaseWrite,
    StReleaseFetch,
    StRun,
    StError
  } LoaderState;

endpackage

// File: rtl/byte_packer.sv
// Shifts bytes into a little-endian 32-bit word; word_valid_o marks the byte that completes it.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        partial_o
);

  localparam logic [1:0] LastByte = 2'(HeaderBytes - 1);

  logic [1:0]  cnt_q, cnt_d, cnt_base;
  logic [23:0] shift_q, shift_d, shift_base;

  // A clear and a byte in the same cycle: the byte starts a fresh word.
  always_comb begin
    cnt_base   = clear_i ? 2'd0 : cnt_q;
    shift_base = clear_i ? 24'd0 : shift_q;
    cnt_d      = cnt_base;
    shift_d    = shift_base;
    if (valid_i) begin
      cnt_d   = cnt_base + 2'd1;
      shift_d = {data_i, shift_base[23:8]};
    end
  end

  assign word_o       = {data_i, shift_base};
  assign word_valid_o = valid_i && (cnt_base == LastByte);
  assign partial_o    = (cnt_q != 2'd0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: loads a length-prefixed UART image into memory, then hands the port to the core.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MEMORY_BYTES   = 65536,
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [31:0] cpu_read_address,
  input  logic [31:0] cpu_write_address,
  input  logic [31:0] cpu_write_data,
  input  logic [3:0]  cpu_write_enable,
  output logic        cpu_reset,
  output logic [31:0] memory_read_address,
  output logic [31:0] memory_write_address,
  output logic [31:0] memory_write_data,
  output logic [3:0]  memory_write_enable,
  output logic        busy,
  output logic        error
);

  localparam int unsigned IdxW     = $clog2(MEMORY_BYTES / 4) + 1;
  localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimeoutW-1:0] TimeoutMax = TimeoutW'(TIMEOUT_CYCLES);

  LoaderState          state_q, state_d;
  logic [IdxW-1:0]     word_idx_q, word_idx_d;
  logic [IdxW-1:0]     words_total_q, words_total_d;
  logic [TimeoutW-1:0] idle_q, idle_d;
  logic [31:0]         wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic [3:0]          wr_en_q, wr_en_d;

  logic        rx_take;
  logic        active;
  logic        timeout;
  logic [31:0] word;
  logic        word_valid;
  logic        partial;
  logic        run;

  assign rx_take = rx_valid && (state_q == StHeader || state_q == StPayload);
  assign active  = (state_q == StHeader && partial) || state_q == StPayload;
  assign timeout = active && (idle_q == TimeoutMax);

  byte_packer u_byte_packer (
    .clk_i        (clock),
    .rst_ni       (reset),
    .clear_i      (timeout),
    .valid_i      (rx_take),
    .data_i       (rx_data),
    .word_o       (word),
    .word_valid_o (word_valid),
    .partial_o    (partial)
  );

  always_comb begin
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    words_total_d = words_total_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_en_d       = 4'h0;

    if (!active || rx_take || timeout) begin
      idle_d = '0;
    end else if (idle_q != TimeoutMax) begin
      idle_d = idle_q + 1'b1;
    end else begin
      idle_d = idle_q;
    end

    case (state_q)
      StHeader: begin
        if (word_valid) begin
          if (word[1:0] != 2'b00 || word > 32'(MEMORY_BYTES)) begin
            state_d = StError;
          end else if (word == 32'd0) begin
            state_d = StReleaseWrite;
          end else begin
            state_d       = StPayload;
            word_idx_d    = '0;
            words_total_d = word[IdxW+1:2];
          end
        end
      end
      StPayload: begin
        if (timeout) begin
          state_d       = StHeader;
          word_idx_d    = '0;
          words_total_d = '0;
        end else if (word_valid) begin
          wr_en_d    = 4'hf;
          wr_addr_d  = 32'({word_idx_q, 2'b00});
          wr_data_d  = word;
          word_idx_d = word_idx_q + 1'b1;
          // Leave on the last word so the final write lands in the release cycle.
          if (word_idx_d == words_total_q) begin
            state_d = StReleaseWrite;
          end
        end
      end
      StReleaseWrite: state_d = StReleaseFetch;
      StReleaseFetch: state_d = StRun;
      StRun:          state_d = StRun;
      StError:        state_d = StError;
      default:        state_d = StError;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StHeader;
      word_idx_q    <= '0;
      words_total_q <= '0;
      idle_q        <= '0;
      wr_addr_q     <= 32'd0;
      wr_data_q     <= 32'd0;
      wr_en_q       <= 4'h0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      words_total_q <= words_total_d;
      idle_q        <= idle_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_en_q       <= wr_en_d;
    end
  end

  assign run = (state_q == StRun);

  assign cpu_reset            = !run;
  assign busy                 = !(run || state_q == StError);
  assign error                = (state_q == StError);
  assign memory_read_address  = run ? cpu_read_address  : 32'd0;
  assign memory_write_address = run ? cpu_write_address : wr_addr_q;
  assign memory_write_data    = run ? cpu_write_data    : wr_data_q;
  assign memory_write_enable  = run ? cpu_write_enable  : wr_en_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: load, error, empty image, timeout and mid-load reset.
module tb_program_loader;

  localparam int unsigned MemBytes = 256;
  localparam int unsigned Timeout  = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [31:0] cpu_read_address  = 32'h0000_0040;
  logic [31:0] cpu_write_address = 32'h0000_0088;
  logic [31:0] cpu_write_data    = 32'hcafe_f00d;
  logic [3:0]  cpu_write_enable  = 4'h3;
  logic        cpu_reset;
  logic [31:0] memory_read_address;
  logic [31:0] memory_write_address;
  logic [31:0] memory_write_data;
  logic [3:0]  memory_write_enable;
  logic        busy;
  logic        error;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  program_loader #(
    .MEMORY_BYTES   (MemBytes),
    .TIMEOUT_CYCLES (Timeout)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .rx_valid             (rx_valid),
    .rx_data              (rx_data),
    .cpu_read_address     (cpu_read_address),
    .cpu_write_address    (cpu_write_address),
    .cpu_write_data       (cpu_write_data),
    .cpu_write_enable     (cpu_write_enable),
    .cpu_reset            (cpu_reset),
    .memory_read_address  (memory_read_address),
    .memory_write_address (memory_write_address),
    .memory_write_data    (memory_write_data),
    .memory_write_enable  (memory_write_enable),
    .busy                 (busy),
    .error                (error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs for the next edge, return 1ns after it.
  task automatic cycle(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clock);
    #1;
  endtask

  task automatic send_word(input string tag, input logic [31:0] w, input logic [3:0] last_we);
    logic [31:0] sh;
    sh = w;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, sh[7:0]);
      sh = sh >> 8;
      check({tag, "_we"}, 32'(memory_write_enable), (i == 3) ? 32'(last_we) : 32'd0);
    end
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    reset    = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic check_run(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rd_addr"}, memory_read_address, 32'h0000_0040);
    check({tag, "_we_pass"}, 32'(memory_write_enable), 32'h3);
  endtask

  initial begin
    // Reset values before any clock edge.
    #1;
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_error", 32'(error), 32'd0);
    check("rst_we", 32'(memory_write_enable), 32'd0);
    check("rst_wr_addr", memory_write_address, 32'd0);
    check("rst_wr_data", memory_write_data, 32'd0);
    check("rst_rd_addr", memory_read_address, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 100; i++) begin
      cycle(1'b0, 8'h00);
      check("idle_cpu_reset", 32'(cpu_reset), 32'd1);
      check("idle_busy", 32'(busy), 32'd1);
      check("idle_error", 32'(error), 32'd0);
      check("idle_we", 32'(memory_write_enable), 32'd0);
    end

    // Two-word image, back-to-back bytes.
    send_word("load_hdr", 32'd8, 4'h0);
    send_word("load_w0", 32'h0000_0513, 4'hf);
    check("load_w0_addr", memory_write_address, 32'h0);
    check("load_w0_data", memory_write_data, 32'h0000_0513);
    send_word("load_w1", 32'h0010_0593, 4'hf);
    check("load_w1_addr", memory_write_address, 32'h4);
    check("load_w1_data", memory_write_data, 32'h0010_0593);
    check("load_w1_cpu_reset", 32'(cpu_reset), 32'd1);
    check("load_w1_busy", 32'(busy), 32'd1);
    cycle(1'b0, 8'h00);
    check("fetch_we", 32'(memory_write_enable), 32'd0);
    check("fetch_rd_addr", memory_read_address, 32'd0);
    check("fetch_cpu_reset", 32'(cpu_reset), 32'd1);
    check("fetch_busy", 32'(busy), 32'd1);
    cycle(1'b0, 8'h00);
    check_run("run");
    check("run_wr_addr", memory_write_address, 32'h0000_0088);
    check("run_wr_data", memory_write_data, 32'hcafe_f00d);
    cpu_read_address = 32'h0000_0123;
    #1;
    check("run_rd_comb", memory_read_address, 32'h0000_0123);
    cpu_read_address = 32'h0000_0040;

    // Misaligned length.
    do_reset();
    send_word("err6_hdr", 32'd6, 4'h0);
    check("err6_error", 32'(error), 32'd1);
    check("err6_busy", 32'(busy), 32'd0);
    check("err6_cpu_reset", 32'(cpu_reset), 32'd1);
    send_word("err6_post0", 32'd4, 4'h0);
    send_word("err6_post1", 32'h4433_2211, 4'h0);
    check("err6_still", 32'(error), 32'd1);

    // Length one word past the memory size.
    do_reset();
    send_word("errbig_hdr", MemBytes + 4, 4'h0);
    check("errbig_error", 32'(error), 32'd1);

    // Length exactly the memory size is accepted.
    do_reset();
    send_word("full_hdr", MemBytes, 4'h0);
    check("full_error", 32'(error), 32'd0);
    check("full_busy", 32'(busy), 32'd1);

    // Empty image.
    do_reset();
    send_word("zero_hdr", 32'd0, 4'h0);
    check("zero_k_cpu_reset", 32'(cpu_reset), 32'd1);
    check("zero_k_busy", 32'(busy), 32'd1);
    cycle(1'b0, 8'h00);
    check("zero_k1_cpu_reset", 32'(cpu_reset), 32'd1);
    check("zero_k1_we", 32'(memory_write_enable), 32'd0);
    cycle(1'b0, 8'h00);
    check_run("zero_k2");

    // Timeout mid-header, then a fresh image.
    do_reset();
    cycle(1'b1, 8'h08);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < int'(Timeout); i++) cycle(1'b0, 8'h00);
    send_word("to_hdr", 32'd4, 4'h0);
    check("to_hdr_error", 32'(error), 32'd0);
    check("to_hdr_busy", 32'(busy), 32'd1);
    send_word("to_w0", 32'hdead_beef, 4'hf);
    check("to_w0_addr", memory_write_address, 32'h0);
    check("to_w0_data", memory_write_data, 32'hdead_beef);
    cycle(1'b0, 8'h00);
    check("to_fetch_cpu_reset", 32'(cpu_reset), 32'd1);
    cycle(1'b0, 8'h00);
    check_run("to_run");

    // Asynchronous reset mid-payload.
    do_reset();
    send_word("mid_hdr", 32'd8, 4'h0);
    send_word("mid_w0", 32'h0000_0513, 4'hf);
    cycle(1'b1, 8'h93);
    cycle(1'b1, 8'h05);
    rx_valid = 1'b0;
    check("mid_pre_data", memory_write_data, 32'h0000_0513);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_we", 32'(memory_write_enable), 32'd0);
    check("mid_rst_wr_data", memory_write_data, 32'd0);
    check("mid_rst_wr_addr", memory_write_address, 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_error", 32'(error), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    send_word("fresh_hdr", 32'd4, 4'h0);
    send_word("fresh_w0", 32'h1234_5678, 4'hf);
    check("fresh_addr", memory_write_address, 32'h0);
    check("fresh_data", memory_write_data, 32'h1234_5678);
    cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);
    check_run("fresh_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
